// File: rtl/time_stamp_sync_master_if.sv
// Time-stamp sync bundle between the master, its host and the slave time-stamp counters.
interface time_stamp_sync_master_if;
  logic        i_set_valid;
  logic [63:0] i_set_time;
  logic        o_set_ready;
  logic        i_sync_en;
  logic        o_time_stamp_sig;
  logic [63:0] o_time_stamp_set;
  logic [63:0] o_time_now;
  logic        o_synced;
  logic [15:0] o_sync_cnt;

  // Master view: receives host requests, drives time base and sync pulse.
  modport master (
    input  i_set_valid, i_set_time, i_sync_en,
    output o_set_ready, o_time_stamp_sig, o_time_stamp_set,
           o_time_now, o_synced, o_sync_cnt
  );

  // Host / observer view.
  modport slave (
    output i_set_valid, i_set_time, i_sync_en,
    input  o_set_ready, o_time_stamp_sig, o_time_stamp_set,
           o_time_now, o_synced, o_sync_cnt
  );
endinterface

// File: rtl/time_stamp_sync_master.sv
// Time-stamp sync master: keeps the 64-bit seconds.fraction time base, accepts
// host time-set requests and emits one-cycle load pulses (set-origin or periodic)
// that every slave time-stamp counter applies on the same edge as the master.
module time_stamp_sync_master #(
  parameter int unsigned CLK_PER_US     = 50,
  parameter logic [63:0] US_INC         = 64'd4295,
  parameter int unsigned SYNC_PERIOD_US = 16000000
) (
  input  logic                            i_clk_50m,
  input  logic                            i_rst,
  time_stamp_sync_master_if.master        ts
);

  localparam int unsigned PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int unsigned CW = $clog2(SYNC_PERIOD_US);
  localparam logic [PW-1:0] PRESC_LAST  = PW'(CLK_PER_US - 1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(SYNC_PERIOD_US - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_SYNC = 2'd2
  } state_e;

  state_e        state_q,      state_d;
  logic [PW-1:0] presc_q,      presc_d;
  logic [CW-1:0] period_q,     period_d;
  logic [63:0]   time_now_q,   time_now_d;
  logic          pend_valid_q, pend_valid_d;
  logic [63:0]   pend_time_q,  pend_time_d;
  logic [63:0]   stamp_set_q,  stamp_set_d;
  logic          synced_q,     synced_d;
  logic [15:0]   sync_cnt_q,   sync_cnt_d;

  logic        us_tick;
  logic        per_fire;
  logic        set_ready;
  logic        set_fire;
  logic        set_pending;
  logic [63:0] pend_value;
  logic [63:0] time_inc;

  // Handshake and tick decode shared by the FSM and the datapath.
  always_comb begin
    us_tick     = (presc_q == PRESC_LAST);
    time_inc    = time_now_q + US_INC;
    set_ready   = !pend_valid_q && (state_q != S_SYNC);
    set_fire    = ts.i_set_valid && set_ready;
    // A request accepted this cycle already counts as pending, so it can win
    // against a periodic request firing in the same cycle.
    set_pending = pend_valid_q || set_fire;
    pend_value  = pend_valid_q ? pend_time_q : ts.i_set_time;
    per_fire    = (state_q == S_RUN) && ts.i_sync_en && us_tick &&
                  (period_q == PERIOD_LAST);
  end

  // State register.
  always_ff @(posedge i_clk_50m or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: flops update with <= so every register samples pre-edge values.
      state_q <= state_d;
    end
  end

  // Next-state logic: set requests beat periodic requests; S_SYNC lasts one cycle.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (set_pending) state_d = S_SYNC;
      S_RUN:   if (set_pending || per_fire) state_d = S_SYNC;
      S_SYNC:  state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: prescaler, time base, period counter, pending set, load value.
  always_comb begin
    presc_d      = us_tick ? '0 : presc_q + PW'(1);
    time_now_d   = us_tick ? time_inc : time_now_q;
    period_d     = period_q;
    pend_valid_d = pend_valid_q;
    pend_time_d  = pend_time_q;
    stamp_set_d  = stamp_set_q;
    synced_d     = synced_q;
    sync_cnt_d   = sync_cnt_q;

    if ((state_q == S_RUN) && ts.i_sync_en && us_tick) begin
      period_d = (period_q == PERIOD_LAST) ? '0 : period_q + CW'(1);
    end

    if (set_fire) begin
      pend_valid_d = 1'b1;
      pend_time_d  = ts.i_set_time;
    end

    // Capture the load value on entry to S_SYNC; held stable until the next pulse.
    if ((state_q != S_SYNC) && (state_d == S_SYNC)) begin
      stamp_set_d = set_pending ? pend_value : time_inc;
    end

    // End of the pulse cycle: master loads exactly what the slaves load, and
    // restarts its prescaler so both ends tick in phase.
    if (state_q == S_SYNC) begin
      time_now_d   = stamp_set_q;
      presc_d      = '0;
      period_d     = '0;
      sync_cnt_d   = sync_cnt_q + 16'd1;
      pend_valid_d = 1'b0;
      synced_d     = synced_q || pend_valid_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge i_clk_50m or posedge i_rst) begin
    if (i_rst) begin
      presc_q      <= '0;
      period_q     <= '0;
      time_now_q   <= '0;
      pend_valid_q <= 1'b0;
      pend_time_q  <= '0;
      stamp_set_q  <= '0;
      synced_q     <= 1'b0;
      sync_cnt_q   <= '0;
    end else begin
      presc_q      <= presc_d;
      period_q     <= period_d;
      time_now_q   <= time_now_d;
      pend_valid_q <= pend_valid_d;
      pend_time_q  <= pend_time_d;
      stamp_set_q  <= stamp_set_d;
      synced_q     <= synced_d;
      sync_cnt_q   <= sync_cnt_d;
    end
  end

  // Outputs: pulse is a decode of the registered state, so it is glitch-free.
  always_comb begin
    ts.o_set_ready      = set_ready;
    ts.o_time_stamp_sig = (state_q == S_SYNC);
    ts.o_time_stamp_set = stamp_set_q;
    ts.o_time_now       = time_now_q;
    ts.o_synced         = synced_q;
    ts.o_sync_cnt       = sync_cnt_q;
  end

endmodule

// File: tb/tb_time_stamp_sync_master.sv
// Scoreboard bench for time_stamp_sync_master: stimulus pushes expected pulses,
// a negedge monitor pops and compares every pulse the DUT emits.
module tb_time_stamp_sync_master;

  localparam int          CLK_PER_US     = 50;
  localparam logic [63:0] US_INC         = 64'd4295;
  localparam int          SYNC_PERIOD_US = 4;

  localparam logic [63:0] T2V = 64'h0000_0010_0000_0000;
  localparam logic [63:0] V4  = 64'h0000_0020_0000_0000;
  localparam logic [63:0] VA  = 64'h0000_0030_0000_0000;
  localparam logic [63:0] VB  = 64'h0000_0040_0000_0000;
  localparam logic [63:0] VC  = 64'h0000_0050_0000_0000;
  localparam logic [63:0] VF  = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct {
    logic [63:0] val;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  exp_t exp_q[$];
  int   pulse_cyc[$];
  exp_t mon_e;
  logic prev_sig = 1'b0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  time_stamp_sync_master_if ts_if ();

  time_stamp_sync_master #(
    .CLK_PER_US    (CLK_PER_US),
    .US_INC        (US_INC),
    .SYNC_PERIOD_US(SYNC_PERIOD_US)
  ) dut (
    .i_clk_50m(clk),
    .i_rst    (rst),
    .ts       (ts_if)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_pulse(input logic [63:0] v, input logic [15:0] c);
    exp_t e;
    e.val = v;
    e.cnt = c;
    exp_q.push_back(e);
  endtask

  function automatic int gap(input int i);
    if (i > 0 && i < pulse_cyc.size()) return pulse_cyc[i] - pulse_cyc[i-1];
    return -1;
  endfunction

  // Monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      prev_sig = 1'b0;
    end else begin
      if (ts_if.o_time_stamp_sig) begin
        check("sig_back_to_back", 64'(prev_sig), 64'd0);
        pulse_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("pulse_value", ts_if.o_time_stamp_set, mon_e.val);
          check("pulse_sync_cnt", 64'(ts_if.o_sync_cnt), 64'(mon_e.cnt));
        end
      end
      prev_sig = ts_if.o_time_stamp_sig;
    end
  end

  initial begin
    ts_if.i_set_valid = 1'b0;
    ts_if.i_set_time  = '0;
    ts_if.i_sync_en   = 1'b1;
    step(3);
    rst = 1'b0;

    // T1: reset values and free-running time base in S_IDLE.
    check("rst_time_now", ts_if.o_time_now, 64'd0);
    check("rst_set_ready", 64'(ts_if.o_set_ready), 64'd1);
    check("rst_synced", 64'(ts_if.o_synced), 64'd0);
    check("rst_sync_cnt", 64'(ts_if.o_sync_cnt), 64'd0);
    check("rst_stamp_set", ts_if.o_time_stamp_set, 64'd0);
    step(49);
    check("t1_before_tick", ts_if.o_time_now, 64'd0);
    step(1);
    check("t1_first_tick", ts_if.o_time_now, 64'd4295);
    step(70);
    check("t1_second_tick", ts_if.o_time_now, 64'd8590);
    check("t1_synced", 64'(ts_if.o_synced), 64'd0);

    // T2: host set.
    ts_if.i_sync_en = 1'b0;
    check("t2_ready_before", 64'(ts_if.o_set_ready), 64'd1);
    ts_if.i_set_valid = 1'b1;
    ts_if.i_set_time  = T2V;
    expect_pulse(T2V, 16'd0);
    step(1);
    ts_if.i_set_valid = 1'b0;
    check("t2_ready_in_sync", 64'(ts_if.o_set_ready), 64'd0);
    step(1);
    check("t2_time_loaded", ts_if.o_time_now, T2V);
    check("t2_synced", 64'(ts_if.o_synced), 64'd1);
    check("t2_sync_cnt", 64'(ts_if.o_sync_cnt), 64'd1);
    check("t2_ready_after", 64'(ts_if.o_set_ready), 64'd1);
    step(49);
    check("t2_before_tick", ts_if.o_time_now, T2V);
    step(1);
    check("t2_after_tick", ts_if.o_time_now, T2V + 64'd4295);

    // T3: set to 0, then periodic pulses every 4 us + 1 clock.
    ts_if.i_sync_en   = 1'b1;
    ts_if.i_set_valid = 1'b1;
    ts_if.i_set_time  = 64'd0;
    expect_pulse(64'd0, 16'd1);
    expect_pulse(64'd17180, 16'd2);
    expect_pulse(64'd34360, 16'd3);
    expect_pulse(64'd51540, 16'd4);
    step(1);
    ts_if.i_set_valid = 1'b0;
    step(1);
    check("t3_time_zero", ts_if.o_time_now, 64'd0);
    step(603);
    check("t3_sync_cnt", 64'(ts_if.o_sync_cnt), 64'd5);
    check("t3_time_now", ts_if.o_time_now, 64'd51540);
    check("t3_gap1", 64'(gap(2)), 64'd201);
    check("t3_gap2", 64'(gap(3)), 64'd201);
    check("t3_gap3", 64'(gap(4)), 64'd201);

    // T4: set handshake on the cycle the periodic request fires.
    step(199);
    ts_if.i_set_valid = 1'b1;
    ts_if.i_set_time  = V4;
    expect_pulse(V4, 16'd5);
    step(1);
    ts_if.i_set_valid = 1'b0;
    step(1);
    check("t4_time_loaded", ts_if.o_time_now, V4);
    check("t4_sync_cnt", 64'(ts_if.o_sync_cnt), 64'd6);
    check("t4_stamp_held", ts_if.o_time_stamp_set, V4);
    expect_pulse(V4 + 64'd17180, 16'd6);
    step(201);
    check("t4_full_period", 64'(gap(6)), 64'd201);
    check("t4_time_now", ts_if.o_time_now, V4 + 64'd17180);
    check("t4_sync_cnt_after", 64'(ts_if.o_sync_cnt), 64'd7);

    // T5: backpressure with a held request and changing data.
    ts_if.i_sync_en = 1'b0;
    check("t5_ready_before", 64'(ts_if.o_set_ready), 64'd1);
    ts_if.i_set_valid = 1'b1;
    ts_if.i_set_time  = VA;
    expect_pulse(VA, 16'd7);
    expect_pulse(VB, 16'd8);
    step(1);
    ts_if.i_set_time = VB;
    check("t5_ready_low", 64'(ts_if.o_set_ready), 64'd0);
    step(1);
    check("t5_ready_back", 64'(ts_if.o_set_ready), 64'd1);
    check("t5_first_value", ts_if.o_time_now, VA);
    step(1);
    ts_if.i_set_valid = 1'b0;
    ts_if.i_set_time  = VC;
    check("t5_ready_low2", 64'(ts_if.o_set_ready), 64'd0);
    step(1);
    check("t5_second_value", ts_if.o_time_now, VB);
    check("t5_sync_cnt", 64'(ts_if.o_sync_cnt), 64'd9);

    // T6: 64-bit wrap, then reset during S_SYNC.
    ts_if.i_set_valid = 1'b1;
    ts_if.i_set_time  = VF;
    expect_pulse(VF, 16'd9);
    step(1);
    ts_if.i_set_valid = 1'b0;
    step(1);
    check("t6_time_max", ts_if.o_time_now, VF);
    step(49);
    check("t6_before_wrap", ts_if.o_time_now, VF);
    step(1);
    check("t6_wrapped", ts_if.o_time_now, 64'd4294);

    ts_if.i_set_valid = 1'b1;
    ts_if.i_set_time  = 64'h1234;
    step(1);
    ts_if.i_set_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("t6_rst_sig", 64'(ts_if.o_time_stamp_sig), 64'd0);
    check("t6_rst_time_now", ts_if.o_time_now, 64'd0);
    check("t6_rst_stamp_set", ts_if.o_time_stamp_set, 64'd0);
    check("t6_rst_sync_cnt", 64'(ts_if.o_sync_cnt), 64'd0);
    check("t6_rst_synced", 64'(ts_if.o_synced), 64'd0);
    check("t6_rst_ready", 64'(ts_if.o_set_ready), 64'd1);
    step(2);
    rst = 1'b0;
    ts_if.i_sync_en = 1'b1;
    step(300);
    check("t6_post_rst_time", ts_if.o_time_now, 64'd25770);
    check("t6_post_rst_cnt", 64'(ts_if.o_sync_cnt), 64'd0);
    check("t6_post_rst_synced", 64'(ts_if.o_synced), 64'd0);
    check("missing_pulses", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/time_stamp_sync_master.md
Name: time_stamp_sync_master

Overview:
- Master/transmitter end of the time-stamp sync interface.
- Keeps the system 64-bit time base: upper 32 bits are seconds, lower 32 bits are binary fraction, advanced by US_INC every microsecond.
- Accepts host time-set requests and drives the one-cycle sync pulse plus 64-bit load value consumed by every slave time-stamp counter.
- Emits a periodic re-sync pulse so slaves cannot drift.

Parameters:
- CLK_PER_US, 50, clock cycles per microsecond tick (2..256).
- US_INC, 4295, time-base increment per microsecond (about 2^32/1e6).
- SYNC_PERIOD_US, 16000000, microsecond ticks between periodic sync pulses (>=2).

Ports:
- i_clk_50m  in  1  system clock.
- i_rst  in  1  asynchronous reset, active-high.
- i_set_valid  in  1  host time-set request.
- i_set_time  in  64  host time value; sampled on handshake.
- o_set_ready  out  1  master can accept a set request.
- i_sync_en  in  1  enables periodic sync pulses (level).
- o_time_stamp_sig  out  1  one-cycle sync/load pulse to slaves.
- o_time_stamp_set  out  64  value slaves load when o_time_stamp_sig=1; held stable between pulses.
- o_time_now  out  64  master's current time base.
- o_synced  out  1  set after the first host set has been applied.
- o_sync_cnt  out  16  count of pulses emitted, wraps at 65535->0.

Behaviour:
- Reset (asynchronous): all outputs are 0 except o_set_ready=1; prescaler=0, period counter=0, pending register clear, FSM=S_IDLE.
- Prescaler counts 0..CLK_PER_US-1. A us tick occurs in the cycle it equals CLK_PER_US-1; it then wraps to 0.
- On each us tick, o_time_now <= o_time_now + US_INC, modulo 2^64, so fraction overflow carries into seconds. Counting runs in all states.
- Set handshake: transfer occurs on i_set_valid && o_set_ready. i_set_time is latched into the pending register and o_set_ready drops the next cycle. o_set_ready is 0 while a set is pending and in S_SYNC.
- Periodic counter: increments on each us tick, but only in S_RUN with i_sync_en=1. When it reaches SYNC_PERIOD_US-1 on a tick, it clears and raises a periodic request. If i_sync_en is 0, the counter holds its value.
- FSM states:
  - S_IDLE: no periodic pulses. A pending set goes to S_SYNC with load value = pending value.
  - S_RUN: a pending set goes to S_SYNC with value = pending. Otherwise a periodic request goes to S_SYNC with value = o_time_now after that tick's increment. If both occur in the same cycle, the set wins, the periodic request is discarded, and the period counter is cleared.
  - S_SYNC: lasts exactly one cycle. o_time_stamp_sig=1 and o_time_stamp_set=load value. At the end of this cycle the following all happen:
    - o_time_now <= o_time_stamp_set;
    - prescaler <= 0;
    - period counter <= 0;
    - o_sync_cnt increments;
    - the pending register clears;
    - o_synced <= 1 for set-origin pulses;
    - the FSM goes to S_RUN;
    - o_set_ready returns to 1 the next cycle.
- Sync pulse timing:
  - o_time_stamp_sig is registered and is never high two consecutive cycles.
  - Slaves load the value and clear their prescaler on the same edge the master does, so master and slave ticks stay phase-aligned.
  - Each periodic pulse stretches that microsecond by one clock, identically on both ends.
- Arithmetic: 64-bit unsigned, no saturation; 0xFFFF_FFFF_FFFF_FFFF + US_INC wraps.
- Reset mid-operation, including during S_SYNC: immediate return to reset values; a pending set is lost.

Test Plan:
- T1, reset and idle: 120 cycles, no set, i_sync_en=1 -> o_time_now=2*4295=8590 after the 2nd tick; o_time_stamp_sig never asserts; o_synced=0.
- T2, host set: i_set_valid with i_set_time=0x0000_0010_0000_0000 -> exactly one sig pulse carrying that value; o_time_now equals it the next cycle and reaches +4295 50 cycles later; o_synced=1; o_sync_cnt=1.
- T3, periodic (SYNC_PERIOD_US=4) after a set to 0 -> pulses every 4*50+1=201 cycles with values 17180, 34360, ...; o_sync_cnt increments by 1 per pulse.
- T4, collision: assert the set on the exact cycle the periodic request fires -> a single pulse carrying the set value; the next periodic pulse comes a full period later.
- T5, backpressure: hold i_set_valid with a changing i_set_time -> o_set_ready=0 until after the pulse; only the first value is transmitted; the second handshake produces a second pulse.
- T6, wrap and reset: set 0xFFFF_FFFF_FFFF_FFFF -> after one tick o_time_now=4294. Assert i_rst during S_SYNC -> outputs go to reset values immediately and no further pulse appears.
